// File: rtl/tx_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler_if
// Bundles the requester-side and Tx-core-side signals of the frame scheduler.
//   req       : per-requester transmit request (level)
//   req_data  : packed requester bytes, requester i at [i*n +: n]
//   req_par   : per-requester parity enable
//   pause     : blocks new grants while high
//   gnt       : one-hot owner of the Tx core
//   ack       : one-cycle accept pulse to the winner
//   done      : one-cycle pulse to the owner on the last frame cycle
//   busy      : scheduler not idle
//   tx_start  : start pulse to the Tx core
//   tx_d      : frame data to the Tx core
//   tx_parity : parity enable to the Tx core
// master : requester / environment side (drives requests, observes results)
// slave  : scheduler side (consumes requests, drives grants and core controls)
// ---------------------------------------------------------------------------
interface tx_frame_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int n     = 8
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*n-1:0] req_data;
    logic [N_REQ-1:0]   req_par;
    logic               pause;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic               tx_start;
    logic [n-1:0]       tx_d;
    logic               tx_parity;

    modport master (
        output req, req_data, req_par, pause,
        input  gnt, ack, done, busy, tx_start, tx_d, tx_parity
    );

    modport slave (
        input  req, req_data, req_par, pause,
        output gnt, ack, done, busy, tx_start, tx_d, tx_parity
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
// Round-robin arbiter sharing one UART Tx serializer between N_REQ byte
// producers. One requester is accepted at a time; the core is held for one
// full frame plus GAP_CYCLES idle cycles before the next grant.
// Ports:
//   clk   : single clock, the Tx core shifts one bit per clk
//   rst_n : asynchronous active-low reset
//   bus   : tx_frame_scheduler_if.slave (requests in, grant/core controls out)
// ---------------------------------------------------------------------------
module tx_frame_scheduler #(
    parameter int N_REQ      = 4,
    parameter int n          = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tx_frame_scheduler_if.slave   bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(n + 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gapCnt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;
    logic             r_txStart;
    logic [n-1:0]     r_txD;
    logic             r_txPar;

    logic [2*N_REQ-1:0] w_reqDbl;
    logic [N_REQ-1:0]   w_rot;
    logic [PW-1:0]      w_offset;
    logic [PW:0]        w_sum;
    logic [PW:0]        w_wrap;
    logic [PW-1:0]      w_winner;
    logic [N_REQ-1:0]   w_winOh;
    logic [n-1:0]       w_selData;
    logic               w_selPar;
    logic [CW-1:0]      w_lastCnt;
    logic [CW-1:0]      w_doneAt;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner's offset.
    assign w_reqDbl = {bus.req, bus.req} >> r_ptr;
    assign w_rot    = w_reqDbl[N_REQ-1:0];

    always_comb begin
        w_offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = PW'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_wrap   = w_sum - NREQ_W;
    assign w_winner = (w_sum >= NREQ_W) ? w_wrap[PW-1:0] : w_sum[PW-1:0];
    assign w_winOh  = N_REQ'(1) << w_winner;

    // Byte and parity select for the winner, captured on the IDLE->LOAD edge.
    always_comb begin
        w_selData = '0;
        w_selPar  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == PW'(k)) begin
                w_selData = bus.req_data[k*n +: n];
                w_selPar  = bus.req_par[k];
            end
        end
    end

    // Frame is start + n data + optional parity + stop. done is registered,
    // so it is loaded one count before the final SEND cycle.
    assign w_lastCnt = r_txPar ? CW'(n + 2) : CW'(n + 1);
    assign w_doneAt  = r_txPar ? CW'(n + 1) : CW'(n);

    // Main FSM. Pulse outputs default low each cycle and are only raised
    // on the edge entering the cycle in which they must be visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_gapCnt  <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_txStart <= 1'b0;
            r_txD     <= '0;
            r_txPar   <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_done    <= '0;
            r_txStart <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.pause && (bus.req != '0)) begin
                        r_state   <= S_LOAD;
                        r_win     <= w_winner;
                        r_gnt     <= w_winOh;
                        r_ack     <= w_winOh;
                        r_txStart <= 1'b1;
                        r_busy    <= 1'b1;
                        r_txD     <= w_selData;
                        r_txPar   <= w_selPar;
                    end
                end
                S_LOAD: begin
                    r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (r_cnt == w_doneAt) begin
                        r_done <= r_gnt;
                    end
                    if (r_cnt == w_lastCnt) begin
                        r_cnt <= '0;
                        r_gnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_gapCnt <= '0;
                            r_state  <= S_GAP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_gapCnt == 4'(GAP_CYCLES - 1)) begin
                        r_gapCnt <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.tx_start  = r_txStart;
    assign bus.tx_d      = r_txD;
    assign bus.tx_parity = r_txPar;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_scheduler
// Directed bench for tx_frame_scheduler. dut1 runs with GAP_CYCLES=1, dut2
// with GAP_CYCLES=0; both share clock and reset.
// ---------------------------------------------------------------------------
module tb_tx_frame_scheduler;
    logic clk;
    logic rst_n;
    int   vecCount;
    int   missCount;
    int   cycleNum;
    int   multiHot;

    tx_frame_scheduler_if #(.N_REQ(4), .n(8)) bus1 ();
    tx_frame_scheduler_if #(.N_REQ(4), .n(8)) bus2 ();

    tx_frame_scheduler #(.N_REQ(4), .n(8), .GAP_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    tx_frame_scheduler #(.N_REQ(4), .n(8), .GAP_CYCLES(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
        cycleNum++;
        if ($countones(bus1.gnt) > 1 || $countones(bus2.gnt) > 1) multiHot++;
    endtask

    task automatic clearInputs;
        bus1.req = '0; bus1.req_data = '0; bus1.req_par = '0; bus1.pause = 1'b0;
        bus2.req = '0; bus2.req_data = '0; bus2.req_par = '0; bus2.pause = 1'b0;
    endtask

    task automatic doReset;
        @(negedge clk);
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Steps until the selected DUT shows tx_start; cycles = -1 on timeout.
    task automatic waitStart(input int which, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((which == 1 && bus1.tx_start) || (which == 2 && bus2.tx_start)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clearInputs();
        #2;
        vecCount++;
        if ({bus1.gnt, bus1.ack, bus1.done, bus1.busy, bus1.tx_start, bus1.tx_d, bus1.tx_parity} !== 23'd0) begin
            missCount++;
            $display("[TB] FAIL reset_outputs: got gnt=%b ack=%b done=%b busy=%b start=%b d=%h par=%b expected all zero",
                     bus1.gnt, bus1.ack, bus1.done, bus1.busy, bus1.tx_start, bus1.tx_d, bus1.tx_parity);
        end
        doReset();
        vecCount++;
        if (bus1.busy !== 1'b0 || bus2.busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_idle_busy: got %b/%b expected 0/0", bus1.busy, bus2.busy);
        end
    endtask

    task automatic test_single_frame;
        bus1.req[2] = 1'b1;
        bus1.req_data[2*8 +: 8] = 8'hA5;
        bus1.req_par[2] = 1'b1;
        step();
        bus1.req = '0;
        vecCount++;
        if (bus1.tx_start !== 1'b1 || bus1.tx_d !== 8'hA5 || bus1.tx_parity !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL single_load: got start=%b d=%h par=%b expected 1/a5/1",
                     bus1.tx_start, bus1.tx_d, bus1.tx_parity);
        end
        vecCount++;
        if (bus1.ack !== 4'b0100 || bus1.gnt !== 4'b0100 || bus1.busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL single_ack_gnt: got ack=%b gnt=%b busy=%b expected 0100/0100/1",
                     bus1.ack, bus1.gnt, bus1.busy);
        end
        for (int i = 1; i <= 11; i++) begin
            step();
            vecCount++;
            if (bus1.done !== ((i == 11) ? 4'b0100 : 4'b0000)) begin
                missCount++;
                $display("[TB] FAIL single_done_c%0d: got %b expected %b", i, bus1.done,
                         (i == 11) ? 4'b0100 : 4'b0000);
            end
        end
        vecCount++;
        if (bus1.gnt !== 4'b0100 || bus1.tx_start !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL single_last_send: got gnt=%b start=%b expected 0100/0", bus1.gnt, bus1.tx_start);
        end
        step();
        vecCount++;
        if (bus1.gnt !== 4'b0000 || bus1.busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL single_gap: got gnt=%b busy=%b expected 0000/1", bus1.gnt, bus1.busy);
        end
        step();
        vecCount++;
        if (bus1.busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL single_idle: got busy=%b expected 0", bus1.busy);
        end
    endtask

    task automatic test_rotation;
        int c;
        int prev;
        logic [3:0] expGnt;
        logic [7:0] expD;
        doReset();
        multiHot = 0;
        bus1.req = 4'b1111;
        for (int i = 0; i < 4; i++) bus1.req_data[i*8 +: 8] = 8'h10 + 8'(i);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            waitStart(1, 20, c);
            expGnt = 4'b0001 << (i % 4);
            expD   = 8'h10 + 8'(i % 4);
            vecCount++;
            if (c < 0 || bus1.gnt !== expGnt || bus1.tx_d !== expD) begin
                missCount++;
                $display("[TB] FAIL rotation_gnt%0d: got gnt=%b d=%h wait=%0d expected gnt=%b d=%h",
                         i, bus1.gnt, bus1.tx_d, c, expGnt, expD);
            end
            if (i > 0) begin
                vecCount++;
                if (cycleNum - prev !== 13) begin
                    missCount++;
                    $display("[TB] FAIL rotation_spacing%0d: got %0d cycles expected 13", i, cycleNum - prev);
                end
            end
            prev = cycleNum;
        end
        bus1.req = '0;
        for (int i = 0; i < 16; i++) step();
        vecCount++;
        if (multiHot !== 0) begin
            missCount++;
            $display("[TB] FAIL rotation_onehot: got %0d multi-hot cycles expected 0", multiHot);
        end
    endtask

    task automatic test_pause;
        int c;
        int starts;
        doReset();
        bus1.req = 4'b0011;
        step();
        vecCount++;
        if (bus1.gnt !== 4'b0001 || bus1.tx_start !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL pause_first_gnt: got gnt=%b start=%b expected 0001/1", bus1.gnt, bus1.tx_start);
        end
        bus1.req = 4'b0010;
        step(); step(); step();
        bus1.pause = 1'b1;
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus1.done != 4'b0000) begin
                c = i;
                break;
            end
        end
        vecCount++;
        if (c < 0 || bus1.done !== 4'b0001) begin
            missCount++;
            $display("[TB] FAIL pause_done: got done=%b after %0d cycles expected 0001", bus1.done, c);
        end
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus1.tx_start !== 1'b0) starts++;
        end
        vecCount++;
        if (starts !== 0 || bus1.busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL pause_blocked: got %0d starts busy=%b expected 0/0", starts, bus1.busy);
        end
        bus1.pause = 1'b0;
        step();
        vecCount++;
        if (bus1.tx_start !== 1'b1 || bus1.gnt !== 4'b0010) begin
            missCount++;
            $display("[TB] FAIL pause_release_load: got start=%b gnt=%b expected 1/0010", bus1.tx_start, bus1.gnt);
        end
        bus1.req = '0;
        for (int i = 0; i < 14; i++) step();
    endtask

    task automatic test_capture_hold;
        int bad;
        int c;
        doReset();
        bus1.req[0] = 1'b1;
        bus1.req_data[7:0] = 8'h3C;
        step();
        vecCount++;
        if (bus1.ack !== 4'b0001 || bus1.tx_d !== 8'h3C || bus1.tx_parity !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL hold_ack: got ack=%b d=%h par=%b expected 0001/3c/0", bus1.ack, bus1.tx_d, bus1.tx_parity);
        end
        step();
        bus1.req[0] = 1'b0;
        bus1.req_data[7:0] = 8'hFF;
        bad = 0;
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus1.tx_d !== 8'h3C) bad++;
            if (bus1.done != 4'b0000) begin
                c = i;
                break;
            end
        end
        vecCount++;
        if (bad !== 0 || c !== 9) begin
            missCount++;
            $display("[TB] FAIL hold_data: got %0d bad cycles done_at=%0d expected 0 bad done_at=9", bad, c);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset_midframe;
        doReset();
        bus1.req[1] = 1'b1;
        bus1.req_data[15:8] = 8'h5A;
        bus1.req_par[1] = 1'b1;
        step();
        bus1.req = '0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        vecCount++;
        if ({bus1.gnt, bus1.ack, bus1.done, bus1.busy, bus1.tx_start, bus1.tx_d, bus1.tx_parity} !== 23'd0) begin
            missCount++;
            $display("[TB] FAIL midreset_outputs: got gnt=%b busy=%b d=%h par=%b expected all zero",
                     bus1.gnt, bus1.busy, bus1.tx_d, bus1.tx_parity);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus1.req = 4'b1000;
        step();
        bus1.req = '0;
        vecCount++;
        if (bus1.gnt !== 4'b1000 || bus1.tx_start !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL midreset_req3: got gnt=%b start=%b expected 1000/1", bus1.gnt, bus1.tx_start);
        end
        // Second pass: a stale ptr of 2 would pick requester 3 instead of 1.
        doReset();
        bus1.req = 4'b0010;
        step();
        bus1.req = '0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus1.req = 4'b1010;
        step();
        bus1.req = '0;
        vecCount++;
        if (bus1.gnt !== 4'b0010) begin
            missCount++;
            $display("[TB] FAIL midreset_ptr0: got gnt=%b expected 0010", bus1.gnt);
        end
        for (int i = 0; i < 16; i++) step();
    endtask

    task automatic test_gap_zero;
        int c;
        int d;
        doReset();
        bus2.req = 4'b0011;
        bus2.req_data[7:0]  = 8'h11;
        bus2.req_data[15:8] = 8'h22;
        waitStart(2, 5, c);
        vecCount++;
        if (c < 0 || bus2.gnt !== 4'b0001) begin
            missCount++;
            $display("[TB] FAIL gap0_first: got gnt=%b wait=%0d expected 0001", bus2.gnt, c);
        end
        bus2.req = 4'b0010;
        d = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus2.done != 4'b0000) begin
                d = i;
                break;
            end
        end
        vecCount++;
        if (d !== 10) begin
            missCount++;
            $display("[TB] FAIL gap0_done: got done after %0d cycles expected 10", d);
        end
        step();
        vecCount++;
        if (bus2.busy !== 1'b0 || bus2.gnt !== 4'b0000 || bus2.tx_start !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL gap0_idle: got busy=%b gnt=%b start=%b expected 0/0000/0",
                     bus2.busy, bus2.gnt, bus2.tx_start);
        end
        step();
        bus2.req = '0;
        vecCount++;
        if (bus2.tx_start !== 1'b1 || bus2.gnt !== 4'b0010 || bus2.tx_d !== 8'h22) begin
            missCount++;
            $display("[TB] FAIL gap0_next_load: got start=%b gnt=%b d=%h expected 1/0010/22",
                     bus2.tx_start, bus2.gnt, bus2.tx_d);
        end
        for (int i = 0; i < 14; i++) step();
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        cycleNum  = 0;
        multiHot  = 0;
        test_reset();
        test_single_frame();
        test_rotation();
        test_pause();
        test_capture_hold();
        test_reset_midframe();
        test_gap_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Round-robin scheduler that shares one UART transmit serializer (the `Dataflow_Tx` core) between `N_REQ` byte producers. It accepts a byte from one requester at a time and issues a one-cycle start pulse with stable data and parity selection to the Tx core. It then holds the core for exactly one frame plus a programmable inter-frame gap before granting the next requester. It sits between the packet/command sources and the Tx core, and is the only block that drives the core's `start_sig`, `D` and `parity_check`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `n`, 8, data bits per frame; must match the Tx core's `n`
- `GAP_CYCLES`, 1, idle cycles inserted after each frame (0..15)
- `clk` input 1: single clock; the Tx core shifts one bit per `clk`
- `rst_n` input 1: asynchronous, active-low reset
- `req` input N_REQ: per-requester transmit request, level
- `req_data` input N_REQ*n: requester i's byte is `req_data[i*n +: n]`
- `req_par` input N_REQ: per-requester parity enable for its frame
- `pause` input 1: when 1, no new grant is issued; the current frame completes
- `gnt` output N_REQ: one-hot owner of the Tx core; 0 when no owner
- `ack` output N_REQ: one-cycle pulse to the accepted requester; data has been captured
- `done` output N_REQ: one-cycle pulse to the owner on the last frame cycle
- `busy` output 1: high in every state except IDLE
- `tx_start` output 1: to core `start_sig`
- `tx_d` output n: to core `D`, registered
- `tx_parity` output 1: to core `parity_check`, registered

## Operation
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE:
  - If `pause`=0 and `req`≠0, select the winner round-robin, starting the search at `ptr` and proceeding upward modulo N_REQ.
  - Capture `req_data` and `req_par` of the winner into `tx_d` and `tx_parity`, set `gnt`, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - `tx_start`=1 and `ack[w]`=1.
  - Set `ptr` = (w+1) mod N_REQ.
  - Clear the counter and go to SEND.
- SEND:
  - Frame length L = n+2 when `tx_parity`=0, or n+3 when `tx_parity`=1 (start + data + optional parity + stop).
  - The counter runs 0..L-1.
  - At count L-1: `done[w]`=1, then go to GAP if `GAP_CYCLES`>0, else to IDLE.
- GAP:
  - `gnt` is 0 and the counter runs 0..GAP_CYCLES-1, then go to IDLE.
- `tx_d` and `tx_parity` hold from the IDLE→LOAD edge until the next capture. Requester inputs are ignored outside IDLE.
- Counter width is $clog2(n+4). It is compared against L-1 and never wraps in normal operation.
- Boundary conditions:
  - Requester drops `req` after `ack`: no effect on the frame in flight.
  - Requester keeps `req` high after `done`: it is eligible again, but only after every other active requester has been served once.
  - All `req` asserted continuously: grants go 0,1,2,3,0,... in strict rotation.
  - `pause` rising during LOAD, SEND or GAP: no effect until IDLE, where it blocks the grant.
  - `req` changes in the same cycle as the IDLE decision: the value sampled at that edge wins.
- Reset (asynchronous, including mid-frame): state=IDLE, `ptr`=0, counter=0. All outputs go to 0 immediately: `gnt`, `ack`, `done`, `busy`, `tx_start`, `tx_d`, `tx_parity`.

## Timing
- `req` is high at edge k (state IDLE) → LOAD during cycle k+1, with `tx_start`, `ack` and `gnt` valid.
- SEND occupies cycles k+2 .. k+1+L; `done` is asserted in cycle k+1+L.
- GAP occupies the next `GAP_CYCLES` cycles. The earliest next LOAD is cycle k+3+L+GAP_CYCLES.
- Minimum frame-to-frame `tx_start` spacing is L+2+GAP_CYCLES cycles.
- `gnt` is high from LOAD through the last SEND cycle.
- `busy` rises with LOAD and falls on entry to IDLE.
- All outputs are registered; no combinational path from `req` to any output.

## Test plan
- Reset, then pulse `req[2]` with `req_data[2]`=8'hA5 and `req_par[2]`=1.
  - One `tx_start` with `tx_d`=8'hA5 and `tx_parity`=1.
  - `ack[2]` in the same cycle; `done[2]` exactly 11 cycles after LOAD (L=11).
- Hold all four `req` high, `GAP_CYCLES`=1, `req_par`=0.
  - Grant order 0,1,2,3,0.
  - `tx_start` spacing is exactly 13 cycles (L+2+GAP_CYCLES = 10+2+1).
  - `gnt` is never multi-hot.
- Assert `pause`=1 mid-SEND with `req[1]` pending.
  - The current frame completes and `done` is seen.
  - No LOAD while `pause`=1; LOAD occurs one cycle after `pause` falls.
- Drop `req[0]` and change `req_data[0]` the cycle after `ack[0]`.
  - `tx_d` stays at the captured value through `done`.
- Assert `rst_n`=0 at SEND count 4.
  - All outputs are 0 without waiting for a clock edge.
  - After release with `req[3]` high, requester 3 is granted with `ptr` restarted at 0.
- Run with `GAP_CYCLES`=0 and two requesters active.
  - LOAD follows the last SEND cycle after exactly one IDLE cycle.
